// File: rtl/red_seq_param.sv
// Sequential lane reducer: sums every LANE_W-bit lane of two DATA_W operands,
// one lane pair per clock, with a valid/ready handshake on both sides.
module red_seq_param #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              signed_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum_out,
    output logic              busy
);

    localparam int NUM_LANES = DATA_W / LANE_W;
    localparam int CNT_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

    // The accumulator must hold 2*NUM_LANES lane values without losing carries.
    generate
        if ((DATA_W % LANE_W) != 0 || LANE_W < 2 ||
            (LANE_W + $clog2(2 * NUM_LANES)) > DATA_W) begin : g_bad_params
            $error("red_seq_param: illegal DATA_W/LANE_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                sgn_q, sgn_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   sum_q, sum_d;

    logic [LANE_W-1:0]   lane_a;
    logic [LANE_W-1:0]   lane_b;
    logic [DATA_W-1:0]   acc_next;
    logic                accept;

    function automatic logic [DATA_W-1:0] ext_lane(input logic [LANE_W-1:0] v,
                                                   input logic            sgn);
        ext_lane = {{(DATA_W - LANE_W){sgn & v[LANE_W-1]}}, v};
    endfunction

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                lane_a = a_q[i*LANE_W +: LANE_W];
                lane_b = b_q[i*LANE_W +: LANE_W];
            end
        end
    end

    assign acc_next = acc_q + ext_lane(lane_a, sgn_q) + ext_lane(lane_b, sgn_q);

    assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM);
    assign sum_out   = sum_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    sgn_d   = signed_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_LANE) begin
                    sum_d   = acc_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Consuming the result and accepting the next pair share one edge.
                if (out_ready) begin
                    if (accept) begin
                        a_d     = a_in;
                        b_d     = b_in;
                        sgn_d   = signed_in;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    // Operand latches carry no reset; they are only read after an accept.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        sgn_q <= sgn_d;
    end

endmodule
